// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the comparator result tally block.
//   - CLS_* : 2-bit classification codes produced by cmp_classify
//   - state_t : FSM states of cmp_result_tally (IDLE -> RUN -> DONE -> IDLE)
// ---------------------------------------------------------------------------
package cmp_pkg;

   localparam logic [1:0] CLS_EQ  = 2'd0;
   localparam logic [1:0] CLS_GA  = 2'd1;
   localparam logic [1:0] CLS_GB  = 2'd2;
   localparam logic [1:0] CLS_ILL = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cmp_result_tally_if.sv
// ---------------------------------------------------------------------------
// cmp_result_tally_if
// Bundles the comparator flag stream, window control and result summary of
// cmp_result_tally.
//   i_start / i_valid           : window start request, sample strobe
//   i_equal .. i_great_b        : comparator flags for the current sample
//   o_busy / o_done             : window in progress / one-cycle end pulse
//   o_cnt_* / o_changes / o_err : registered results of the last window
// Modports: master = flag source / result reader, slave = tally block.
// ---------------------------------------------------------------------------
interface cmp_result_tally_if #(
   parameter int CNT_W = 8
);

   logic             i_start;
   logic             i_valid;
   logic             i_equal;
   logic             i_not_equal;
   logic             i_great_a;
   logic             i_great_b;
   logic             o_busy;
   logic             o_done;
   logic [CNT_W-1:0] o_cnt_equal;
   logic [CNT_W-1:0] o_cnt_great_a;
   logic [CNT_W-1:0] o_cnt_great_b;
   logic [CNT_W-1:0] o_changes;
   logic             o_err;

   modport master (
      output i_start, i_valid, i_equal, i_not_equal, i_great_a, i_great_b,
      input  o_busy, o_done, o_cnt_equal, o_cnt_great_a, o_cnt_great_b,
             o_changes, o_err
   );

   modport slave (
      input  i_start, i_valid, i_equal, i_not_equal, i_great_a, i_great_b,
      output o_busy, o_done, o_cnt_equal, o_cnt_great_a, o_cnt_great_b,
             o_changes, o_err
   );

endinterface

// File: rtl/cmp_classify.sv
// ---------------------------------------------------------------------------
// cmp_classify
// Purely combinational decode of the four comparator flags into a class.
//   equal, not_equal, great_a, great_b : comparator flags
//   cls : CLS_EQ / CLS_GA / CLS_GB, or CLS_ILL for any inconsistent combination
// ---------------------------------------------------------------------------
module cmp_classify
   import cmp_pkg::*;
(
   input  logic       equal,
   input  logic       not_equal,
   input  logic       great_a,
   input  logic       great_b,
   output logic [1:0] cls
);

   // Only the three self-consistent flag patterns are legal; everything else
   // (including all-zero) points at a broken comparator.
   always_comb begin
      cls = CLS_ILL;
      case ({equal, not_equal, great_a, great_b})
         4'b1000: cls = CLS_EQ;
         4'b0110: cls = CLS_GA;
         4'b0101: cls = CLS_GB;
         default: cls = CLS_ILL;
      endcase
   end

endmodule

// File: rtl/cmp_result_tally.sv
// ---------------------------------------------------------------------------
// cmp_result_tally
// Tallies comparator outcomes over a window of WINDOW valid samples started
// by i_start, counts outcome changes between consecutive legal samples and
// flags illegal flag combinations.
//   i_clk  : clock, all state on rising edge
//   i_rst  : synchronous active-high reset
//   bus    : cmp_result_tally_if.slave (start/valid/flags in, summary out)
// Parameters:
//   CNT_W  : width of every counter output (counters saturate)
//   WINDOW : valid samples per measurement window (1 .. 65535)
// ---------------------------------------------------------------------------
module cmp_result_tally
   import cmp_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int WINDOW = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   cmp_result_tally_if.slave   bus
);

   localparam logic [15:0]      WIN_LAST = 16'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       cls;
   logic [1:0]       prev_cls;
   logic             prev_valid;
   logic [15:0]      sample_cnt;
   logic [CNT_W-1:0] cnt_equal;
   logic [CNT_W-1:0] cnt_great_a;
   logic [CNT_W-1:0] cnt_great_b;
   logic [CNT_W-1:0] changes;
   logic             err;
   logic             start_acc;
   logic             accept;
   logic             last_sample;

   cmp_classify u_classify (
      .equal     (bus.i_equal),
      .not_equal (bus.i_not_equal),
      .great_a   (bus.i_great_a),
      .great_b   (bus.i_great_b),
      .cls       (cls)
   );

   // A start only counts in IDLE; samples only count in RUN, so a sample
   // arriving together with the start is dropped.
   assign start_acc   = (state == ST_IDLE) && bus.i_start;
   assign accept      = (state == ST_RUN) && bus.i_valid;
   assign last_sample = accept && (sample_cnt == WIN_LAST);

   // Next-state logic: DONE is a single-cycle pulse state.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start_acc)   state_nxt = ST_RUN;
         ST_RUN:  if (last_sample) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Result registers. They are cleared by a new start and otherwise hold,
   // so the last window's summary stays readable while idle. An illegal
   // sample uses up a slot but leaves the previous legal class untouched, so
   // change detection bridges across it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sample_cnt  <= '0;
         prev_cls    <= CLS_EQ;
         prev_valid  <= 1'b0;
         cnt_equal   <= '0;
         cnt_great_a <= '0;
         cnt_great_b <= '0;
         changes     <= '0;
         err         <= 1'b0;
      end else if (start_acc) begin
         sample_cnt  <= '0;
         prev_valid  <= 1'b0;
         cnt_equal   <= '0;
         cnt_great_a <= '0;
         cnt_great_b <= '0;
         changes     <= '0;
         err         <= 1'b0;
      end else if (accept) begin
         sample_cnt <= sample_cnt + 16'd1;
         case (cls)
            CLS_EQ:  cnt_equal   <= sat_inc(cnt_equal);
            CLS_GA:  cnt_great_a <= sat_inc(cnt_great_a);
            CLS_GB:  cnt_great_b <= sat_inc(cnt_great_b);
            default: err         <= 1'b1;
         endcase
         if (cls != CLS_ILL) begin
            if (prev_valid && (cls != prev_cls)) changes <= sat_inc(changes);
            prev_cls   <= cls;
            prev_valid <= 1'b1;
         end
      end
   end

   assign bus.o_busy        = (state == ST_RUN);
   assign bus.o_done        = (state == ST_DONE);
   assign bus.o_cnt_equal   = cnt_equal;
   assign bus.o_cnt_great_a = cnt_great_a;
   assign bus.o_cnt_great_b = cnt_great_b;
   assign bus.o_changes     = changes;
   assign bus.o_err         = err;

endmodule

// File: tb/tb_cmp_result_tally.sv
// ---------------------------------------------------------------------------
// tb_cmp_result_tally
// Drives the same stimulus into two tally instances (CNT_W=8 and CNT_W=3,
// both WINDOW=16) and compares every output after every clock against a
// reference built from the list of classes accepted in the current window.
// ---------------------------------------------------------------------------
module tb_cmp_result_tally;
   import cmp_pkg::*;

   localparam int WINDOW = 16;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       start;
   logic       valid;
   logic [3:0] flags;   // {equal, not_equal, great_a, great_b}

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [1:0] hist[$];

   always #5 i_clk = ~i_clk;

   cmp_result_tally_if #(.CNT_W(8)) bus8 ();
   cmp_result_tally_if #(.CNT_W(3)) bus3 ();

   assign bus8.i_start     = start;
   assign bus8.i_valid     = valid;
   assign bus8.i_equal     = flags[3];
   assign bus8.i_not_equal = flags[2];
   assign bus8.i_great_a   = flags[1];
   assign bus8.i_great_b   = flags[0];
   assign bus3.i_start     = start;
   assign bus3.i_valid     = valid;
   assign bus3.i_equal     = flags[3];
   assign bus3.i_not_equal = flags[2];
   assign bus3.i_great_a   = flags[1];
   assign bus3.i_great_b   = flags[0];

   cmp_result_tally #(.CNT_W(8), .WINDOW(WINDOW)) dut8 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus8)
   );

   cmp_result_tally #(.CNT_W(3), .WINDOW(WINDOW)) dut3 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Flags a correct 2-bit comparator would produce for operands a and b.
   function automatic logic [3:0] cmp_flags(input int a, input int b);
      logic [3:0] f;
      f[3] = (a == b);
      f[2] = (a != b);
      f[1] = (a > b);
      f[0] = (b > a);
      return f;
   endfunction

   function automatic logic [1:0] model_class(input logic [3:0] f);
      if (f == cmp_flags(1, 1)) return CLS_EQ;
      if (f == cmp_flags(1, 0)) return CLS_GA;
      if (f == cmp_flags(0, 1)) return CLS_GB;
      return CLS_ILL;
   endfunction

   function automatic int sat(input int x, input int max);
      return (x > max) ? max : x;
   endfunction

   // Sample flags for the idx-th valid sample of a window in a given mode.
   function automatic logic [3:0] gen_flags(input int mode, input int idx);
      int a;
      case (mode)
         0: begin
            case (idx % 4)
               0:       return cmp_flags(0, 0);
               1:       return cmp_flags(1, 0);
               2:       return cmp_flags(0, 1);
               default: return cmp_flags(1, 1);
            endcase
         end
         1: begin
            a = int'($urandom_range(0, 3));
            return cmp_flags(a, a);
         end
         2: begin
            if (idx == 4) return cmp_flags(1, 0) | 4'b1000;
            return cmp_flags(1, 0);
         end
         3:       return cmp_flags(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         default: return 4'($urandom_range(0, 15));
      endcase
   endfunction

   task automatic apply_stimulus(input logic s, input logic v, input logic [3:0] f,
                                 input logic r);
      start = s;
      valid = v;
      flags = f;
      i_rst = r;
      @(posedge i_clk);
      #1;
   endtask

   // Compares both instances with the tally of the classes accepted so far.
   task automatic check_output(input string tag, input logic exp_busy, input logic exp_done);
      int   n_eq;
      int   n_ga;
      int   n_gb;
      int   n_chg;
      logic any_ill;
      logic have_last;
      logic [1:0] last;
      n_eq = 0; n_ga = 0; n_gb = 0; n_chg = 0;
      any_ill = 1'b0; have_last = 1'b0; last = CLS_EQ;
      foreach (hist[i]) begin
         if (hist[i] == CLS_ILL) any_ill = 1'b1;
         else begin
            if (hist[i] == CLS_EQ) n_eq++;
            if (hist[i] == CLS_GA) n_ga++;
            if (hist[i] == CLS_GB) n_gb++;
            if (have_last && hist[i] != last) n_chg++;
            last = hist[i];
            have_last = 1'b1;
         end
      end
      chk({tag, "_busy8"}, 32'(bus8.o_busy), 32'(exp_busy));
      chk({tag, "_done8"}, 32'(bus8.o_done), 32'(exp_done));
      chk({tag, "_busy3"}, 32'(bus3.o_busy), 32'(exp_busy));
      chk({tag, "_done3"}, 32'(bus3.o_done), 32'(exp_done));
      chk({tag, "_eq8"},   32'(bus8.o_cnt_equal),   sat(n_eq, 255));
      chk({tag, "_ga8"},   32'(bus8.o_cnt_great_a), sat(n_ga, 255));
      chk({tag, "_gb8"},   32'(bus8.o_cnt_great_b), sat(n_gb, 255));
      chk({tag, "_chg8"},  32'(bus8.o_changes),     sat(n_chg, 255));
      chk({tag, "_err8"},  32'(bus8.o_err),         32'(any_ill));
      chk({tag, "_eq3"},   32'(bus3.o_cnt_equal),   sat(n_eq, 7));
      chk({tag, "_ga3"},   32'(bus3.o_cnt_great_a), sat(n_ga, 7));
      chk({tag, "_gb3"},   32'(bus3.o_cnt_great_b), sat(n_gb, 7));
      chk({tag, "_chg3"},  32'(bus3.o_changes),     sat(n_chg, 7));
      chk({tag, "_err3"},  32'(bus3.o_err),         32'(any_ill));
   endtask

   // One window: start (with a simultaneous sample that must be dropped),
   // WINDOW valid samples with optional gaps / start pokes, the DONE cycle,
   // then two idle cycles. abort_at >= 0 asserts reset on that valid sample.
   // gap: 0 = valid every cycle, 1 = every other cycle, 2 = random.
   task automatic run_window(input int mode, input int gap, input bit poke, input int abort_at);
      int   n_acc;
      int   cyc;
      logic v;
      logic s;
      logic [3:0] f;
      hist.delete();
      apply_stimulus(1'b1, 1'b1, cmp_flags(1, 0), 1'b0);
      check_output("start", 1'b1, 1'b0);
      n_acc = 0;
      cyc = 0;
      while (n_acc < WINDOW && cyc < 200) begin
         cyc++;
         if (gap == 0)      v = 1'b1;
         else if (gap == 1) v = logic'(cyc % 2);
         else               v = logic'($urandom_range(0, 1));
         s = poke ? logic'($urandom_range(0, 1)) : 1'b0;
         f = gen_flags(mode, n_acc);
         if (v && abort_at >= 0 && n_acc == abort_at) begin
            apply_stimulus(s, v, f, 1'b1);
            hist.delete();
            check_output("abort", 1'b0, 1'b0);
            apply_stimulus(1'b0, 1'b1, f, 1'b0);
            check_output("abort_idle", 1'b0, 1'b0);
            return;
         end
         apply_stimulus(s, v, f, 1'b0);
         if (v) begin
            hist.push_back(model_class(f));
            n_acc++;
         end
         if (n_acc == WINDOW) check_output("done", 1'b0, 1'b1);
         else                 check_output("run", 1'b1, 1'b0);
      end
      chk("window_len", 32'(n_acc), WINDOW);
      // Start during DONE is ignored; results hold while idle.
      apply_stimulus(1'b1, 1'b1, cmp_flags(0, 1), 1'b0);
      check_output("post_done", 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b1, cmp_flags(0, 1), 1'b0);
      check_output("idle_hold", 1'b0, 1'b0);
   endtask

   initial begin
      $display("[TB] cmp_result_tally bench start");
      apply_stimulus(1'b0, 1'b0, 4'b0000, 1'b1);
      apply_stimulus(1'b1, 1'b1, cmp_flags(1, 0), 1'b1);
      hist.delete();
      check_output("reset", 1'b0, 1'b0);

      // Comparator sweep EQ,GA,GB,EQ x4
      run_window(0, 0, 1'b0, -1);
      chk("sweep_eq",  32'(bus8.o_cnt_equal),   8);
      chk("sweep_ga",  32'(bus8.o_cnt_great_a), 4);
      chk("sweep_gb",  32'(bus8.o_cnt_great_b), 4);
      chk("sweep_chg", 32'(bus8.o_changes),     12);
      chk("sweep_eq3", 32'(bus3.o_cnt_equal),   7);

      // All EQ: narrow counter saturates
      run_window(1, 0, 1'b0, -1);
      chk("alleq_eq3", 32'(bus3.o_cnt_equal), 7);
      chk("alleq_chg", 32'(bus8.o_changes),   0);

      // GA stream with one illegal sample
      run_window(2, 0, 1'b0, -1);
      chk("ill_ga",  32'(bus8.o_cnt_great_a), 15);
      chk("ill_err", 32'(bus8.o_err),         1);

      // Gapped valid with start pokes during RUN
      run_window(0, 1, 1'b1, -1);
      chk("gap_chg", 32'(bus8.o_changes), 12);

      // Reset on the 8th sample, then a clean sweep
      run_window(0, 0, 1'b0, 7);
      run_window(0, 0, 1'b0, -1);
      chk("rerun_eq", 32'(bus8.o_cnt_equal), 8);

      // Randomized windows
      for (int k = 0; k < 8; k++) begin
         run_window(3 + (k % 2), 2, bit'($urandom_range(0, 1)), -1);
      end
      run_window(4, 2, 1'b1, int'($urandom_range(0, WINDOW - 1)));
      run_window(3, 0, 1'b0, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
